// File: rtl/register_read_stage_if.sv
// Bus between decode, the register-read stage, the register file, the bypass network and execute.
// The master side is the environment around the stage; the slave side is the stage itself.
interface register_read_stage_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREG   = 8,
  parameter int unsigned IMM_W  = 6,
  parameter int unsigned CNT_W  = 16
);
  localparam int unsigned ADDR_W = $clog2(NREG);

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_opcode;
  logic [ADDR_W-1:0] in_ra;
  logic [ADDR_W-1:0] in_rb;
  logic [ADDR_W-1:0] in_rc;
  logic [IMM_W-1:0]  in_imm;
  logic [ADDR_W-1:0] rf_addr1;
  logic [ADDR_W-1:0] rf_addr2;
  logic [DATA_W-1:0] rf_data1;
  logic [DATA_W-1:0] rf_data2;
  logic              ex_wr_en;
  logic              ex_is_load;
  logic [ADDR_W-1:0] ex_wr_addr;
  logic [DATA_W-1:0] ex_wr_data;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        out_opcode;
  logic [DATA_W-1:0] out_op1;
  logic [DATA_W-1:0] out_op2;
  logic [ADDR_W-1:0] out_dest;
  logic              illegal;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output flush, in_valid, in_opcode, in_ra, in_rb, in_rc, in_imm,
    output rf_data1, rf_data2,
    output ex_wr_en, ex_is_load, ex_wr_addr, ex_wr_data,
    output mem_wr_en, mem_wr_addr, mem_wr_data, out_ready,
    input  in_ready, rf_addr1, rf_addr2,
    input  out_valid, out_opcode, out_op1, out_op2, out_dest, illegal, stall_cnt
  );

  modport slave (
    input  flush, in_valid, in_opcode, in_ra, in_rb, in_rc, in_imm,
    input  rf_data1, rf_data2,
    input  ex_wr_en, ex_is_load, ex_wr_addr, ex_wr_data,
    input  mem_wr_en, mem_wr_addr, mem_wr_data, out_ready,
    output in_ready, rf_addr1, rf_addr2,
    output out_valid, out_opcode, out_op1, out_op2, out_dest, illegal, stall_cnt
  );
endinterface

// File: rtl/register_read_stage.sv
// Register-read stage: operand read with EX/MEM bypass, load-use stall detection and a
// valid/ready output register so execute back-pressure reaches decode.
module register_read_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREG   = 8,
  parameter int unsigned IMM_W  = 6,
  parameter int unsigned CNT_W  = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  register_read_stage_if.slave bus
);
  localparam int unsigned ADDR_W = $clog2(NREG);
  localparam logic [3:0] OpAdi = 4'b0000;
  localparam logic [3:0] OpAdd = 4'b0001;
  localparam logic [3:0] OpNdu = 4'b0010;
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic              w_is_adi, w_is_rr, w_legal;
  logic              w_haz1, w_haz2, w_hazard, w_in_ready, w_accept;
  logic [DATA_W-1:0] w_fwd1, w_fwd2, w_imm_ext, w_op2;
  logic [ADDR_W-1:0] w_dest;

  logic              r_out_valid, r_illegal;
  logic [3:0]        r_opcode;
  logic [DATA_W-1:0] r_op1, r_op2;
  logic [ADDR_W-1:0] r_dest;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic              w_out_valid_d, w_illegal_d, w_load;
  logic [CNT_W-1:0]  w_stall_cnt_d;

  assign w_is_adi = (bus.in_opcode == OpAdi);
  assign w_is_rr  = (bus.in_opcode == OpAdd) || (bus.in_opcode == OpNdu);
  assign w_legal  = w_is_adi || w_is_rr;

  assign bus.rf_addr1 = bus.in_ra;
  assign bus.rf_addr2 = bus.in_rb;

  // EX bypass beats MEM; a load in EX has no data yet and must stall instead.
  assign w_fwd1 = (bus.ex_wr_en && !bus.ex_is_load && bus.ex_wr_addr == bus.in_ra) ? bus.ex_wr_data :
                  (bus.mem_wr_en && bus.mem_wr_addr == bus.in_ra) ? bus.mem_wr_data : bus.rf_data1;
  assign w_fwd2 = (bus.ex_wr_en && !bus.ex_is_load && bus.ex_wr_addr == bus.in_rb) ? bus.ex_wr_data :
                  (bus.mem_wr_en && bus.mem_wr_addr == bus.in_rb) ? bus.mem_wr_data : bus.rf_data2;

  assign w_imm_ext = {{(DATA_W-IMM_W){bus.in_imm[IMM_W-1]}}, bus.in_imm};
  assign w_op2     = w_is_adi ? w_imm_ext : w_fwd2;
  assign w_dest    = w_is_adi ? bus.in_rb : bus.in_rc;

  // src2 is only live for register-register ops.
  assign w_haz1   = w_legal && bus.ex_wr_en && bus.ex_is_load && (bus.ex_wr_addr == bus.in_ra);
  assign w_haz2   = w_is_rr && bus.ex_wr_en && bus.ex_is_load && (bus.ex_wr_addr == bus.in_rb);
  assign w_hazard = bus.in_valid && (w_haz1 || w_haz2);

  assign w_in_ready   = !bus.flush && !w_hazard && (!r_out_valid || bus.out_ready);
  assign w_accept     = bus.in_valid && w_in_ready;
  assign bus.in_ready = w_in_ready;

  always_comb begin
    w_out_valid_d = r_out_valid;
    w_illegal_d   = 1'b0;
    w_load        = 1'b0;
    w_stall_cnt_d = r_stall_cnt;
    if (bus.flush) begin
      w_out_valid_d = 1'b0;
    end else if (w_accept && w_legal) begin
      w_out_valid_d = 1'b1;
      w_load        = 1'b1;
    end else begin
      if (bus.out_ready) w_out_valid_d = 1'b0;
      if (w_accept)      w_illegal_d   = 1'b1;
    end
    if (w_hazard && !bus.flush && r_stall_cnt != CntMax) begin
      w_stall_cnt_d = r_stall_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_illegal   <= 1'b0;
      r_opcode    <= '0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_dest      <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_out_valid <= w_out_valid_d;
      r_illegal   <= w_illegal_d;
      r_stall_cnt <= w_stall_cnt_d;
      if (w_load) begin
        r_opcode <= bus.in_opcode;
        r_op1    <= w_fwd1;
        r_op2    <= w_op2;
        r_dest   <= w_dest;
      end
    end
  end

  assign bus.out_valid  = r_out_valid;
  assign bus.out_opcode = r_opcode;
  assign bus.out_op1    = r_op1;
  assign bus.out_op2    = r_op2;
  assign bus.out_dest   = r_dest;
  assign bus.illegal    = r_illegal;
  assign bus.stall_cnt  = r_stall_cnt;
endmodule

// File: tb/tb_register_read_stage.sv
// Directed bench for register_read_stage: vector table plus hand sequences for stall,
// back-pressure, flush/illegal, counter saturation and asynchronous reset.
module tb_register_read_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  register_read_stage_if #(.DATA_W(16), .NREG(8), .IMM_W(6), .CNT_W(16)) m_if ();
  register_read_stage_if #(.DATA_W(16), .NREG(8), .IMM_W(6), .CNT_W(2))  s_if ();

  register_read_stage #(.DATA_W(16), .NREG(8), .IMM_W(6), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(m_if.slave)
  );
  register_read_stage #(.DATA_W(16), .NREG(8), .IMM_W(6), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(s_if.slave)
  );

  logic [15:0] rf [8];
  assign m_if.rf_data1 = rf[m_if.rf_addr1];
  assign m_if.rf_data2 = rf[m_if.rf_addr2];
  assign s_if.rf_data1 = 16'h0;
  assign s_if.rf_data2 = 16'h0;

  typedef struct {
    logic [3:0] op; logic [2:0] ra, rb, rc; logic [5:0] imm;
    logic ex_en, ex_ld; logic [2:0] ex_a; logic [15:0] ex_d;
    logic mem_en; logic [2:0] mem_a; logic [15:0] mem_d;
    logic [15:0] e_op1, e_op2; logic [2:0] e_dest;
  } vec_t;

  vec_t vecs[8];
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    m_if.in_opcode = v.op; m_if.in_ra = v.ra; m_if.in_rb = v.rb; m_if.in_rc = v.rc;
    m_if.in_imm = v.imm;
    m_if.ex_wr_en = v.ex_en; m_if.ex_is_load = v.ex_ld; m_if.ex_wr_addr = v.ex_a;
    m_if.ex_wr_data = v.ex_d;
    m_if.mem_wr_en = v.mem_en; m_if.mem_wr_addr = v.mem_a; m_if.mem_wr_data = v.mem_d;
  endtask

  task automatic post_edge();
    @(posedge clk);
    #1;
  endtask

  vec_t idle;
  vec_t v;

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = 16'h0;
    rf[1] = 16'd5; rf[2] = 16'd7; rf[3] = 16'h0033; rf[4] = 16'h0044;
    idle = '{4'h1, 3'd0, 3'd0, 3'd0, 6'd0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0,
             16'h0, 16'h0, 3'd0};
    vecs[0] = '{4'h1, 3'd1, 3'd2, 3'd3, 6'd0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0,
                16'd5, 16'd7, 3'd3};
    vecs[1] = vecs[0];
    vecs[2] = vecs[0];
    vecs[3] = '{4'h0, 3'd1, 3'd4, 3'd0, 6'h3E, 1'b1, 1'b0, 3'd1, 16'h0010, 1'b1, 3'd1, 16'h0099,
                16'h0010, 16'hFFFE, 3'd4};
    vecs[4] = '{4'h1, 3'd1, 3'd2, 3'd5, 6'd0, 1'b1, 1'b0, 3'd3, 16'hDEAD, 1'b1, 3'd2, 16'h1234,
                16'd5, 16'h1234, 3'd5};
    vecs[5] = '{4'h2, 3'd3, 3'd4, 3'd6, 6'd0, 1'b1, 1'b1, 3'd7, 16'h0, 1'b1, 3'd4, 16'h5555,
                16'h0033, 16'h5555, 3'd6};
    vecs[6] = '{4'h0, 3'd2, 3'd3, 3'd0, 6'h05, 1'b1, 1'b1, 3'd3, 16'h0, 1'b0, 3'd0, 16'h0,
                16'd7, 16'd5, 3'd3};
    vecs[7] = '{4'h1, 3'd4, 3'd4, 3'd7, 6'd0, 1'b1, 1'b0, 3'd4, 16'hBEEF, 1'b1, 3'd4, 16'h1111,
                16'hBEEF, 16'hBEEF, 3'd7};

    drive(idle);
    m_if.flush = 1'b0; m_if.in_valid = 1'b0; m_if.out_ready = 1'b1;
    s_if.flush = 1'b0; s_if.in_valid = 1'b0; s_if.out_ready = 1'b1;
    s_if.in_opcode = 4'h1; s_if.in_ra = 3'd5; s_if.in_rb = 3'd0; s_if.in_rc = 3'd0;
    s_if.in_imm = 6'd0; s_if.ex_wr_en = 1'b0; s_if.ex_is_load = 1'b0; s_if.ex_wr_addr = 3'd0;
    s_if.ex_wr_data = 16'h0; s_if.mem_wr_en = 1'b0; s_if.mem_wr_addr = 3'd0;
    s_if.mem_wr_data = 16'h0;

    #1;
    chk("reset out_valid", m_if.out_valid, 0);
    chk("reset out_op1", m_if.out_op1, 0);
    chk("reset stall_cnt", m_if.stall_cnt, 0);
    chk("reset illegal", m_if.illegal, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: one accept per cycle with out_ready held high.
    m_if.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk($sformatf("vec%0d in_ready", i), m_if.in_ready, 1);
      post_edge();
      chk($sformatf("vec%0d out_valid", i), m_if.out_valid, 1);
      chk($sformatf("vec%0d op1", i), m_if.out_op1, vecs[i].e_op1);
      chk($sformatf("vec%0d op2", i), m_if.out_op2, vecs[i].e_op2);
      chk($sformatf("vec%0d dest", i), m_if.out_dest, vecs[i].e_dest);
      chk($sformatf("vec%0d illegal", i), m_if.illegal, 0);
    end
    chk("rf_addr1 follows ra", m_if.rf_addr1, 4);

    // Load-use stall: NDU R2,R3 against a load to R3 held in EX for two cycles.
    v = '{4'h2, 3'd2, 3'd3, 3'd1, 6'd0, 1'b1, 1'b1, 3'd3, 16'h0, 1'b0, 3'd0, 16'h0,
          16'd7, 16'hABCD, 3'd1};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(v);
      #1;
      chk($sformatf("stall%0d in_ready", i), m_if.in_ready, 0);
      post_edge();
      chk($sformatf("stall%0d out_valid", i), m_if.out_valid, 0);
    end
    chk("stall_cnt after 2", m_if.stall_cnt, 2);
    @(negedge clk);
    v.ex_en = 1'b0; v.ex_ld = 1'b0; v.mem_en = 1'b1; v.mem_a = 3'd3; v.mem_d = 16'hABCD;
    drive(v);
    #1;
    chk("release in_ready", m_if.in_ready, 1);
    post_edge();
    chk("release out_valid", m_if.out_valid, 1);
    chk("release op1", m_if.out_op1, 7);
    chk("release op2", m_if.out_op2, 16'hABCD);
    chk("release dest", m_if.out_dest, 1);
    chk("release stall_cnt", m_if.stall_cnt, 2);

    // Back-pressure.
    @(negedge clk);
    m_if.in_valid = 1'b0;
    drive(idle);
    post_edge();
    @(negedge clk);
    drive(vecs[0]);
    m_if.in_valid = 1'b1;
    m_if.out_ready = 1'b0;
    post_edge();
    chk("bp first valid", m_if.out_valid, 1);
    @(negedge clk);
    v = '{4'h1, 3'd4, 3'd1, 3'd2, 6'd0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0,
          16'h0044, 16'd5, 3'd2};
    drive(v);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp%0d in_ready", i), m_if.in_ready, 0);
      post_edge();
      chk($sformatf("bp%0d valid", i), m_if.out_valid, 1);
      chk($sformatf("bp%0d op1", i), m_if.out_op1, 5);
      chk($sformatf("bp%0d op2", i), m_if.out_op2, 7);
      chk($sformatf("bp%0d dest", i), m_if.out_dest, 3);
      @(negedge clk);
    end
    m_if.out_ready = 1'b1;
    #1;
    chk("bp release in_ready", m_if.in_ready, 1);
    post_edge();
    chk("bp second valid", m_if.out_valid, 1);
    chk("bp second op1", m_if.out_op1, 16'h0044);
    chk("bp second op2", m_if.out_op2, 5);
    chk("bp second dest", m_if.out_dest, 2);

    // Flush with a valid result and an instruction presented.
    @(negedge clk);
    m_if.flush = 1'b1;
    m_if.out_ready = 1'b0;
    drive(vecs[0]);
    #1;
    chk("flush in_ready", m_if.in_ready, 0);
    post_edge();
    chk("flush out_valid", m_if.out_valid, 0);
    chk("flush illegal", m_if.illegal, 0);
    @(negedge clk);
    m_if.flush = 1'b0;
    m_if.out_ready = 1'b1;
    v = vecs[0];
    v.op = 4'hF;
    drive(v);
    #1;
    chk("illegal in_ready", m_if.in_ready, 1);
    post_edge();
    chk("illegal pulse", m_if.illegal, 1);
    chk("illegal out_valid", m_if.out_valid, 0);
    @(negedge clk);
    m_if.in_valid = 1'b0;
    post_edge();
    chk("illegal one cycle", m_if.illegal, 0);
    chk("illegal still no valid", m_if.out_valid, 0);

    // Saturating counter on the narrow-counter instance.
    @(negedge clk);
    s_if.in_valid = 1'b1; s_if.ex_wr_en = 1'b1; s_if.ex_is_load = 1'b1; s_if.ex_wr_addr = 3'd5;
    for (int i = 0; i < 5; i++) post_edge();
    chk("sat stall_cnt", s_if.stall_cnt, 3);
    chk("sat in_ready", s_if.in_ready, 0);

    // Async reset between edges with a held result in the main instance.
    @(negedge clk);
    drive(vecs[0]);
    m_if.in_valid = 1'b1;
    post_edge();
    chk("pre-reset valid", m_if.out_valid, 1);
    @(negedge clk);
    m_if.in_valid = 1'b0;
    m_if.out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async out_valid", m_if.out_valid, 0);
    chk("async opcode", m_if.out_opcode, 0);
    chk("async op1", m_if.out_op1, 0);
    chk("async op2", m_if.out_op2, 0);
    chk("async dest", m_if.out_dest, 0);
    chk("async stall_cnt", m_if.stall_cnt, 0);
    chk("async sat stall_cnt", s_if.stall_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post-reset hazard in_ready", s_if.in_ready, 0);
    chk("post-reset idle in_ready", m_if.in_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
